sram_bus_arbiter: RTL

//  Shares one sram-like bus (req/addr_ok/data_ok) between the IF-stage instruction port and the MEM-stage data port.

---
 rtl/sram_bus_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one sram-like bus between the instruction port and
// the data port. Request phases are arbitrated (data over inst by default),
// outstanding transactions are tracked in an in-order ID FIFO, and responses
// are routed back to their originator. A flush cancels in-flight inst
// responses; data responses always complete.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternating grant when both
// ports request; default build uses fixed data-over-inst priority).
module sram_bus_arbiter #(
   parameter int unsigned OUTST_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   // instruction port
   input  logic        i_inst_req,
   input  logic        i_inst_wr,
   input  logic [1:0]  i_inst_size,
   input  logic [31:0] i_inst_addr,
   input  logic [31:0] i_inst_wdata,
   output logic        o_inst_addr_ok,
   output logic        o_inst_data_ok,
   output logic [31:0] o_inst_rdata,
   // data port
   input  logic        i_data_req,
   input  logic        i_data_wr,
   input  logic [1:0]  i_data_size,
   input  logic [31:0] i_data_addr,
   input  logic [31:0] i_data_wdata,
   output logic        o_data_addr_ok,
   output logic        o_data_data_ok,
   output logic [31:0] o_data_rdata,
   // pipeline flush (exception or ertn)
   input  logic        i_flush,
   // shared bus
   output logic        o_bus_req,
   output logic        o_bus_wr,
   output logic [1:0]  o_bus_size,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_wdata,
   input  logic        i_bus_addr_ok,
   input  logic        i_bus_data_ok,
   input  logic [31:0] i_bus_rdata
);

   localparam int unsigned PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   // grant / FIFO id encoding: 0 = data port, 1 = inst port
   localparam logic GNT_DATA = 1'b0;
   localparam logic GNT_INST = 1'b1;

   // ID FIFO state
   logic [PTR_W-1:0]       r_rd_ptr;
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [CNT_W-1:0]       r_count;
   logic [OUTST_DEPTH-1:0] r_fifo_id;
   logic [OUTST_DEPTH-1:0] r_fifo_disc;

   // request-phase lock: holds the grant while a request waits for addr_ok
   logic                   r_lock;
   logic                   r_grant_q;

`ifdef ARB_ROUND_ROBIN_EN
   // owner of the most recent accepted handshake
   logic                   r_last_grant;
`endif

   logic                   w_grant;
   logic                   w_gnt_req;
   logic                   w_full;
   logic                   w_bus_req;
   logic                   w_accept;
   logic                   w_pop;
   logic                   w_head_id;
   logic                   w_head_disc;
   logic [OUTST_DEPTH-1:0] w_valid;

   // grant selection: lock holds previous grant, otherwise priority/alternation
   always_comb begin
      w_grant = GNT_DATA;
      if (r_lock) begin
         w_grant = r_grant_q;
      end
`ifdef ARB_ROUND_ROBIN_EN
      else if (i_data_req && i_inst_req) begin
         w_grant = ~r_last_grant;
      end
`endif
      else if (i_data_req) begin
         w_grant = GNT_DATA;
      end
      else if (i_inst_req) begin
         w_grant = GNT_INST;
      end
   end

   // bus request fields are muxed from the granted requester
   always_comb begin
      if (w_grant == GNT_INST) begin
         w_gnt_req   = i_inst_req;
         o_bus_wr    = i_inst_wr;
         o_bus_size  = i_inst_size;
         o_bus_addr  = i_inst_addr;
         o_bus_wdata = i_inst_wdata;
      end else begin
         w_gnt_req   = i_data_req;
         o_bus_wr    = i_data_wr;
         o_bus_size  = i_data_size;
         o_bus_addr  = i_data_addr;
         o_bus_wdata = i_data_wdata;
      end
   end

   // handshake qualification; a full FIFO blocks requests with no pop bypass
   always_comb begin
      w_full      = (r_count == CNT_W'(OUTST_DEPTH));
      w_bus_req   = w_gnt_req && !w_full && !i_reset;
      w_accept    = w_bus_req && i_bus_addr_ok;
      w_pop       = i_bus_data_ok && (r_count != '0) && !i_reset;
      w_head_id   = r_fifo_id[r_rd_ptr];
      w_head_disc = r_fifo_disc[r_rd_ptr];
   end

   // occupancy of each FIFO slot, measured from the read pointer
   always_comb begin
      w_valid = '0;
      for (int i = 0; i < int'(OUTST_DEPTH); i++) begin
         w_valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - r_rd_ptr)} < r_count);
      end
   end

   // port-facing handshakes and response routing
   always_comb begin
      o_bus_req      = w_bus_req;
      o_inst_addr_ok = w_accept && (w_grant == GNT_INST);
      o_data_addr_ok = w_accept && (w_grant == GNT_DATA);
      o_data_data_ok = w_pop && (w_head_id == GNT_DATA);
      o_inst_data_ok = w_pop && (w_head_id == GNT_INST) && !w_head_disc && !i_flush;
      o_inst_rdata   = i_bus_rdata;
      o_data_rdata   = i_bus_rdata;
   end

   // ID FIFO: push on accept, pop on response, flush marks pending inst entries
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_fifo_id   <= '0;
         r_fifo_disc <= '0;
      end else begin
         if (i_flush) begin
            for (int i = 0; i < int'(OUTST_DEPTH); i++) begin
               if (w_valid[i] && (r_fifo_id[i] == GNT_INST) &&
                   !(w_pop && (PTR_W'(i) == r_rd_ptr))) begin
                  r_fifo_disc[i] <= 1'b1;
               end
            end
         end
         if (w_accept) begin
            r_fifo_id[r_wr_ptr]   <= w_grant;
            r_fifo_disc[r_wr_ptr] <= (w_grant == GNT_INST) ? i_flush : 1'b0;
            r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // request lock: keep bus fields stable until the bus accepts
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_lock    <= 1'b0;
         r_grant_q <= GNT_DATA;
      end else if (i_flush && r_lock && (r_grant_q == GNT_INST)) begin
         r_lock <= 1'b0;
      end else if (w_bus_req && !i_bus_addr_ok) begin
         r_lock    <= 1'b1;
         r_grant_q <= w_grant;
      end else if (i_bus_addr_ok) begin
         r_lock <= 1'b0;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // remember who won the last accepted handshake
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_last_grant <= GNT_INST;
      end else if (w_accept) begin
         r_last_grant <= w_grant;
      end
   end
`endif

endmodule
